// File: rtl/vision_pkg.sv
// vision_pkg: shared pixel-pipeline types and widths.
//   pixel_t  - 8-bit raw pixel value
//   PAIR_W   - width of a horizontal pair sum (two pixels)
//   SUM_W    - width of a full 2x2 block sum (four pixels)
package vision_pkg;

    typedef logic [7:0] pixel_t;

    localparam int PAIR_W = 9;
    localparam int SUM_W  = 10;

endpackage

// File: rtl/linebuf_ram.sv
// linebuf_ram: simple dual-port line buffer, one write port and one
// registered read port (data valid the cycle after re is sampled).
// The read register holds its value until the next read.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   re    - read enable
//   raddr - read address
//   rdata - registered read data
module linebuf_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/pixel_bin2x2.sv
// pixel_bin2x2: 2x2 binning of a raster pixel stream.
// Even rows store horizontal pair sums in a line buffer; odd rows add the
// stored pair to the current pair and emit the block mean (sum >> 2).
// Build option: define PIXEL_BIN_ROUND_EN to round ((sum + 2) >> 2)
// instead of truncating.
// Ports:
//   clk         - clock, rising edge
//   rst         - asynchronous active-high reset
//   i_sof/i_eof - first/last pixel of input frame (qualified by i_vld)
//   i_dat       - input pixel, raster order
//   i_vld       - input pixel strobe, no backpressure
//   o_sof/o_eof - first/last binned pixel of frame
//   o_dat       - binned pixel
//   o_vld       - binned pixel strobe, one cycle
//   o_frame_err - one-cycle pulse on a framing violation
module pixel_bin2x2
    import vision_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROWS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sof,
    input  logic       i_eof,
    input  logic [7:0] i_dat,
    input  logic       i_vld,
    output logic       o_sof,
    output logic       o_eof,
    output logic [7:0] o_dat,
    output logic       o_vld,
    output logic       o_frame_err
);

    localparam int CW = $clog2(COLS);
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;
    localparam int AW = $clog2(COLS / 2);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

`ifdef PIXEL_BIN_ROUND_EN
    localparam logic [SUM_W-1:0] RND = SUM_W'(2);
`else
    localparam logic [SUM_W-1:0] RND = '0;
`endif

    if ((COLS % 2) != 0 || COLS < 4) begin : g_bad_cols
        $error("pixel_bin2x2: COLS must be even and >= 4");
    end
    if ((ROWS % 2) != 0 || ROWS < 2) begin : g_bad_rows
        $error("pixel_bin2x2: ROWS must be even and >= 2");
    end

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pixel_t        pix_q, pix_d;
    logic          o_sof_q, o_sof_d;
    logic          o_eof_q, o_eof_d;
    logic          o_vld_q, o_vld_d;
    logic          o_err_q, o_err_d;
    pixel_t        o_dat_q, o_dat_d;

    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              at_last;
    logic              take;
    logic              we, re;
    logic [AW-1:0]     lb_addr;
    logic [PAIR_W-1:0] pair;
    logic [PAIR_W-1:0] rdata;
    logic [SUM_W-1:0]  sum;
    pixel_t            binned;

    linebuf_ram #(
        .DEPTH (COLS / 2),
        .WIDTH (PAIR_W)
    ) u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr (lb_addr),
        .wdata (pair),
        .re    (re),
        .raddr (lb_addr),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pix_d   = pix_q;
        o_sof_d = 1'b0;
        o_eof_d = 1'b0;
        o_vld_d = 1'b0;
        o_err_d = 1'b0;
        o_dat_d = o_dat_q;
        we      = 1'b0;
        re      = 1'b0;
        take    = 1'b0;

        // A start-of-frame pixel is always position (0,0), even mid-frame.
        cur_col = i_sof ? '0 : col_q;
        cur_row = i_sof ? '0 : row_q;
        at_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

        lb_addr = cur_col[CW-1:1];
        pair    = {1'b0, pix_q} + {1'b0, i_dat};
        sum     = {1'b0, rdata} + {1'b0, pair};
        binned  = pixel_t'((sum + RND) >> 2);

        if (i_vld) begin
            if (i_sof) begin
                o_err_d = (state_q == ST_ACTIVE);
                state_d = ST_ACTIVE;
                take    = 1'b1;
            end else if (state_q == ST_ACTIVE) begin
                // End-of-frame must coincide exactly with the last position.
                if (i_eof != at_last) begin
                    o_err_d = 1'b1;
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    take = 1'b1;
                end
            end
        end

        if (take) begin
            if (!cur_col[0]) begin
                pix_d = i_dat;
                re    = cur_row[0];
            end else if (!cur_row[0]) begin
                we = 1'b1;
            end else begin
                o_vld_d = 1'b1;
                o_dat_d = binned;
                o_sof_d = (cur_row == RW'(1)) && (cur_col == CW'(1));
                o_eof_d = at_last;
            end

            if (at_last) begin
                state_d = ST_IDLE;
                col_d   = '0;
                row_d   = '0;
            end else if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            o_sof_q <= 1'b0;
            o_eof_q <= 1'b0;
            o_vld_q <= 1'b0;
            o_err_q <= 1'b0;
            o_dat_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pix_q   <= pix_d;
            o_sof_q <= o_sof_d;
            o_eof_q <= o_eof_d;
            o_vld_q <= o_vld_d;
            o_err_q <= o_err_d;
            o_dat_q <= o_dat_d;
        end
    end

    assign o_sof       = o_sof_q;
    assign o_eof       = o_eof_q;
    assign o_vld       = o_vld_q;
    assign o_frame_err = o_err_q;
    assign o_dat       = o_dat_q;

endmodule

// File: tb/tb_pixel_bin2x2.sv
// tb_pixel_bin2x2: directed bench for pixel_bin2x2 (COLS=16, ROWS=12).
module tb_pixel_bin2x2;

    localparam int COLS = 16;
    localparam int ROWS = 12;
    localparam int NPIX = COLS * ROWS;

`ifdef PIXEL_BIN_ROUND_EN
    localparam logic [7:0] SUM3_EXP = 8'd1;
`else
    localparam logic [7:0] SUM3_EXP = 8'd0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       i_sof, i_eof, i_vld;
    logic [7:0] i_dat;
    logic       o_sof, o_eof, o_vld, o_frame_err;
    logic [7:0] o_dat;

    int checks   = 0;
    int failures = 0;

    logic       cap_vld, cap_sof, cap_eof, cap_err;
    logic [7:0] cap_dat;
    int         n_out;
    logic [7:0] first_dat;

    always #5 clk = ~clk;

    pixel_bin2x2 #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sof       (i_sof),
        .i_eof       (i_eof),
        .i_dat       (i_dat),
        .i_vld       (i_vld),
        .o_sof       (o_sof),
        .o_eof       (o_eof),
        .o_dat       (o_dat),
        .o_vld       (o_vld),
        .o_frame_err (o_frame_err)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pval(input int mode, input int r, input int c);
        case (mode)
            0: return 8'h40;
            1: return 8'(c + r * 16);
            2: return 8'hFF;
            3: return 8'(r * 37 + c * 11 + 5);
            default: begin
                if (r % 2 == 0) return 8'd0;
                else if (c % 2 == 0) return 8'd1;
                else return 8'd2;
            end
        endcase
    endfunction

    function automatic logic [7:0] model(input int mode, input int r, input int c);
        int s;
        s = int'(pval(mode, r - 1, c - 1)) + int'(pval(mode, r - 1, c))
          + int'(pval(mode, r, c - 1)) + int'(pval(mode, r, c));
`ifdef PIXEL_BIN_ROUND_EN
        s = s + 2;
`endif
        return 8'(s >> 2);
    endfunction

    // Drive one pixel at a falling edge, capture outputs one cycle later.
    task automatic pix(input logic [7:0] d, input logic sof, input logic eof, input int gap);
        i_vld = 1'b1;
        i_dat = d;
        i_sof = sof;
        i_eof = eof;
        @(negedge clk);
        cap_vld = o_vld;
        cap_sof = o_sof;
        cap_eof = o_eof;
        cap_err = o_frame_err;
        cap_dat = o_dat;
        i_vld = 1'b0;
        i_sof = 1'b0;
        i_eof = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_range(input int mode, input int first, input int last, input bit gaps);
        int r;
        int c;
        int g;
        n_out = 0;
        for (int idx = first; idx <= last; idx++) begin
            r = idx / COLS;
            c = idx % COLS;
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            pix(pval(mode, r, c), idx == 0, idx == NPIX - 1, g);
            check("o_vld", 16'(cap_vld), 16'((r % 2 == 1) && (c % 2 == 1)));
            check("o_frame_err", 16'(cap_err), 16'(0));
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                n_out++;
                if (n_out == 1) first_dat = cap_dat;
                check("o_dat", 16'(cap_dat), 16'(model(mode, r, c)));
                check("o_sof", 16'(cap_sof), 16'((r == 1) && (c == 1)));
                check("o_eof", 16'(cap_eof), 16'(idx == NPIX - 1));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_vld"}, 16'(o_vld), 16'(0));
        check({tag, "_sof"}, 16'(o_sof), 16'(0));
        check({tag, "_eof"}, 16'(o_eof), 16'(0));
        check({tag, "_err"}, 16'(o_frame_err), 16'(0));
        check({tag, "_dat"}, 16'(o_dat), 16'(0));
    endtask

    initial begin
        rst   = 1'b1;
        i_sof = 1'b0;
        i_eof = 1'b0;
        i_vld = 1'b0;
        i_dat = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Constant frame.
        send_range(0, 0, NPIX - 1, 1'b0);
        check("const_count", 16'(n_out), 16'(48));
        check("const_first", 16'(first_dat), 16'h40);

        // Incrementing frame.
        send_range(1, 0, NPIX - 1, 1'b0);
        check("incr_count", 16'(n_out), 16'(48));

        // Block 0,0,1,2 and all-0xFF.
        send_range(4, 0, NPIX - 1, 1'b0);
        check("sum3_dat", 16'(first_dat), 16'(SUM3_EXP));
        send_range(2, 0, NPIX - 1, 1'b0);
        check("ff_dat", 16'(first_dat), 16'hFF);

        // Start-of-frame reasserted at row 5 col 3: restart with that pixel.
        send_range(1, 0, 5 * COLS + 2, 1'b0);
        pix(pval(1, 0, 0), 1'b1, 1'b0, 0);
        check("resof_err", 16'(cap_err), 16'(1));
        check("resof_vld", 16'(cap_vld), 16'(0));
        send_range(1, 1, NPIX - 1, 1'b0);
        check("resof_count", 16'(n_out), 16'(48));

        // Early end-of-frame at row 11 col 7.
        send_range(1, 0, 11 * COLS + 6, 1'b0);
        pix(pval(1, 11, 7), 1'b0, 1'b1, 0);
        check("early_eof_err", 16'(cap_err), 16'(1));
        check("early_eof_eof", 16'(cap_eof), 16'(0));
        check("early_eof_vld", 16'(cap_vld), 16'(0));
        for (int k = 0; k < 8; k++) begin
            pix(8'h55, 1'b0, 1'b0, 0);
            check("idle_vld", 16'(cap_vld), 16'(0));
            check("idle_err", 16'(cap_err), 16'(0));
        end
        send_range(3, 0, NPIX - 1, 1'b1);
        check("after_eof_count", 16'(n_out), 16'(48));

        // Last position without end-of-frame.
        send_range(0, 0, NPIX - 2, 1'b0);
        pix(8'h40, 1'b0, 1'b0, 0);
        check("miss_eof_err", 16'(cap_err), 16'(1));
        check("miss_eof_eof", 16'(cap_eof), 16'(0));
        for (int k = 0; k < 4; k++) begin
            pix(8'h40, 1'b0, 1'b0, 0);
            check("miss_idle_vld", 16'(cap_vld), 16'(0));
        end

        // Reset mid row 7, then a gapped frame.
        send_range(1, 0, 7 * COLS + 5, 1'b0);
        rst = 1'b1;
        #1;
        check_zero("mid_rst_a");
        @(negedge clk);
        check_zero("mid_rst_b");
        @(negedge clk);
        check_zero("mid_rst_c");
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pix(8'h77, 1'b0, 1'b0, 0);
            check("post_rst_vld", 16'(cap_vld), 16'(0));
        end
        send_range(3, 0, NPIX - 1, 1'b1);
        check("post_rst_count", 16'(n_out), 16'(48));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_bin2x2.md
PIXEL_BIN2X2 -- requirements
Module: pixel_bin2x2

Interface
REQ-001 SHALL have parameter COLS, default 16, input pixels per line (even, >=4).
REQ-002 SHALL have parameter ROWS, default 12, input lines per frame (even, >=2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_sof  input  1  first pixel of frame, qualified by i_vld.
REQ-006 SHALL have port i_eof  input  1  last pixel of frame, qualified by i_vld.
REQ-007 SHALL have port i_dat  input  8  pixel value, raster order.
REQ-008 SHALL have port i_vld  input  1  pixel valid strobe; no backpressure.
REQ-009 SHALL have port o_sof  output  1  first binned pixel of frame.
REQ-010 SHALL have port o_eof  output  1  last binned pixel of frame.
REQ-011 SHALL have port o_dat  output  8  binned pixel value.
REQ-012 SHALL have port o_vld  output  1  binned pixel valid, single-cycle.
REQ-013 SHALL have port o_frame_err  output  1  one-cycle pulse on framing violation.

Function
REQ-014 SHALL run FSM IDLE/ACTIVE; IDLE ignores pixels until i_vld&i_sof, which enters ACTIVE at col 0, row 0.
REQ-015 SHALL keep col counter (0..COLS-1) and row counter (0..ROWS-1), advanced only on i_vld; col wraps to 0 and increments row.
REQ-016 SHALL form a 9-bit horizontal pair sum of pixels at cols 2k and 2k+1.
REQ-017 SHALL on even rows write pair sum to line buffer entry k; no output.
REQ-018 SHALL on odd rows add line-buffer entry k to current pair sum (10-bit, no overflow) and output sum>>2 (rounded per REQ-029).
REQ-019 SHALL assert o_vld exactly 1 cycle after the i_vld of the odd-row, odd-col pixel; output rate is one per 4 input pixels.
REQ-020 SHALL assert o_sof with first output (row 1, col 1) and o_eof with last output (row ROWS-1, col COLS-1).
REQ-021 SHALL return to IDLE after accepting i_eof at row ROWS-1, col COLS-1.
REQ-022 SHALL, on i_sof while ACTIVE, pulse o_frame_err, discard partial frame, restart at col 0, row 0 with that pixel.
REQ-023 SHALL, on i_eof at any other position, pulse o_frame_err, emit no o_eof, return to IDLE.
REQ-024 SHALL, on i_vld at row ROWS-1, col COLS-1 without i_eof, pulse o_frame_err and return to IDLE.
REQ-025 SHALL tolerate arbitrary idle gaps between i_vld pulses, including across line boundaries.

Reset
REQ-026 SHALL on rst force IDLE, counters 0, o_vld/o_sof/o_eof/o_frame_err 0, o_dat 0.
REQ-027 SHALL not require line buffer contents to be cleared by reset.
REQ-028 SHALL, when rst asserts mid-frame, drop the frame; no output until next i_sof.

Configuration
REQ-029 SHALL with macro PIXEL_BIN_ROUND_EN defined compute o_dat=(sum+2)>>2; without it o_dat=sum>>2 (truncate).

Structure
REQ-030 SHALL place pixel_t (8-bit) typedef and pair-sum width constant in shared package vision_pkg.
REQ-031 SHALL instantiate sub-module linebuf_ram: COLS/2 x 9-bit simple dual-port, 1-cycle registered read, read address issued on even-col pixel of odd row.
REQ-032 SHALL check COLS and ROWS even at elaboration and fail otherwise.

Verification
REQ-033 Constant frame, all pixels 0x40, COLS=16 ROWS=12 -> 48 outputs of 0x40, o_sof on first, o_eof on 48th, no o_frame_err.
REQ-034 Incrementing frame (pixel = col+row*16, 8-bit) -> output (r,c) = truncated/rounded mean of 2x2 block, matches model with and without PIXEL_BIN_ROUND_EN.
REQ-035 Block values 0,0,1,2 (sum 3) -> o_dat 0 truncate, 1 round; all 0xFF -> 0xFF either mode.
REQ-036 i_sof reasserted at row 5 col 3 -> one o_frame_err pulse, next full frame yields 48 correct outputs.
REQ-037 i_eof at row 11 col 7 -> o_frame_err pulse, no o_eof, FSM IDLE, pixels ignored until i_sof.
REQ-038 rst pulse mid row 7, then full frame with random i_vld gaps -> all outputs 0 during reset, then 48 correct outputs.
